// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
// Contents:
//   MC_ADDR_W / MC_DATA_W  default address and data widths
//   SIZE_BYTE/HALF/WORD    encodings of the MEM-stage access size
//   state_t                controller states (IDLE, RD, WR)
//   owner_t                which requester owns the transaction in flight
//   byte_count()           access size -> number of bus bytes (1, 2 or 4)
package mem_ctrl_pkg;

  localparam int MC_ADDR_W = 32;
  localparam int MC_DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  // The reserved encoding 11 is served as a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the request/response and RAM bus signals of the memory controller.
// Signals:
//   if_req/if_addr/if_flush        fetch request in; if_done/if_inst fetch response out
//   mr_req/mr_we/mr_size/mr_addr/mr_wdata  MEM-stage request in
//   mr_done/mr_rdata               MEM-stage response out
//   mem_din                        RAM read byte in
//   mem_dout/mem_a/mem_wr          RAM write byte, address, write strobe out
// Modports:
//   slave   the controller side
//   master  the pipeline + RAM side
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [DATA_W-1:0] if_inst;

  logic              mr_req;
  logic              mr_we;
  logic [1:0]        mr_size;
  logic [ADDR_W-1:0] mr_addr;
  logic [DATA_W-1:0] mr_wdata;
  logic              mr_done;
  logic [DATA_W-1:0] mr_rdata;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mr_req, mr_we, mr_size, mr_addr, mr_wdata,
    input  mem_din,
    output if_done, if_inst, mr_done, mr_rdata,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mr_req, mr_we, mr_size, mr_addr, mr_wdata,
    output mem_din,
    input  if_done, if_inst, mr_done, mr_rdata,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller between the pipeline and an 8-bit RAM/IO bus.
// Assembles 32-bit little-endian fetch words and serves 1/2/4-byte MEM-stage
// loads and stores, one transaction at a time, MEM winning over fetch.
// Ports:
//   clk_in  single clock
//   rst_in  asynchronous active-high reset
//   rdy_in  global ready; while low every register holds its value
//   bus     mem_ctrl_if.slave: fetch port, MEM port and RAM bus
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  mem_ctrl_if.slave bus
);

  state_t            state;
  owner_t            owner;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] mr_rdata_q;
  logic              if_done_q;
  logic              mr_done_q;
  logic              mem_wr_q;
  logic [7:0]        mem_dout_q;

  logic              flush_hit;
  logic [DATA_W-1:0] next_rd;
  logic [5:0]        align_shift;
  logic [DATA_W-1:0] aligned;

  // A flush only aborts a fetch that is actually on the bus.
  assign flush_hit = bus.if_flush && (state != IDLE) && (owner == OWN_IF);

  // Read bytes enter at the top of the shift register; once the last byte
  // is in, short accesses are shifted down so the result is zero-extended.
  assign next_rd     = {bus.mem_din, data_sr[DATA_W-1:8]};
  assign align_shift = {3'(3'd4 - nbytes), 3'b000};
  assign aligned     = next_rd >> align_shift;

  // Read: cnt counts bytes captured; the RAM returns a byte one cycle after
  // its address, so capture starts with cnt=1 and ends with cnt=nbytes.
  // Write: cnt counts bytes already placed on the bus.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      addr_q     <= '0;
      data_sr    <= '0;
      if_inst_q  <= '0;
      mr_rdata_q <= '0;
      if_done_q  <= 1'b0;
      mr_done_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= 8'd0;
    end else if (rdy_in) begin
      if_done_q <= 1'b0;
      mr_done_q <= 1'b0;
      if (flush_hit) begin
        state  <= IDLE;
        cnt    <= 3'd0;
        addr_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.mr_req) begin
              owner  <= OWN_MEM;
              nbytes <= byte_count(bus.mr_size);
              addr_q <= bus.mr_addr;
              if (bus.mr_we) begin
                state      <= WR;
                cnt        <= 3'd1;
                mem_wr_q   <= 1'b1;
                mem_dout_q <= bus.mr_wdata[7:0];
                data_sr    <= bus.mr_wdata >> 8;
              end else begin
                state   <= RD;
                cnt     <= 3'd0;
                data_sr <= '0;
              end
            end else if (bus.if_req) begin
              owner   <= OWN_IF;
              nbytes  <= 3'd4;
              addr_q  <= bus.if_addr;
              state   <= RD;
              cnt     <= 3'd0;
              data_sr <= '0;
            end
          end
          RD: begin
            if (cnt != 3'd0) data_sr <= next_rd;
            if (cnt == nbytes) begin
              state <= IDLE;
              cnt   <= 3'd0;
              if (owner == OWN_IF) begin
                if_done_q <= 1'b1;
                if_inst_q <= aligned;
              end else begin
                mr_done_q  <= 1'b1;
                mr_rdata_q <= aligned;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if ((cnt + 3'd1) < nbytes) addr_q <= addr_q + ADDR_W'(1);
            end
          end
          WR: begin
            if (cnt == nbytes) begin
              state     <= IDLE;
              cnt       <= 3'd0;
              mem_wr_q  <= 1'b0;
              mr_done_q <= 1'b1;
            end else begin
              cnt        <= cnt + 3'd1;
              addr_q     <= addr_q + ADDR_W'(1);
              mem_dout_q <= data_sr[7:0];
              data_sr    <= data_sr >> 8;
            end
          end
          default: begin
            state    <= IDLE;
            mem_wr_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.mr_done  = mr_done_q;
  assign bus.mr_rdata = mr_rdata_q;
  assign bus.mem_a    = addr_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q;

endmodule
